// File: rtl/neuron_stream_mac_if.sv
// Beat/result handshake bundle for neuron_stream_mac.
// Carries mode, bias, in_valid/in_ready, w, x, out_valid/out_ready, out_data.
interface neuron_stream_mac_if #(
    parameter int N     = 16,
    parameter int LANES = 4
);
    logic [1:0]         mode;
    logic [N-1:0]       bias;
    logic               in_valid;
    logic               in_ready;
    logic [N*LANES-1:0] w;
    logic [N*LANES-1:0] x;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_data;

    modport master (
        output mode, bias, in_valid, w, x, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  mode, bias, in_valid, w, x, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_stream_mac.sv
// Streaming lane-parallel neuron: y = act(sum(W*X) + bias), LANES pairs/beat.
// Ports: clk, rst_n (sync, active low), bus (slave modport of neuron_stream_mac_if).
module neuron_stream_mac #(
    parameter int N        = 16,
    parameter int FRAC     = 8,
    parameter int N_INPUTS = 16,
    parameter int LANES    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    neuron_stream_mac_if.slave bus
);
    localparam int BEATS = N_INPUTS / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ACC_W = 2 * N + $clog2(N_INPUTS) + 1;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_ACC,
        S_ACT,
        S_OUT
    } state_t;

    state_t                   r_state, w_state_nx;
    logic [CNT_W-1:0]         r_beat_cnt, w_beat_cnt_nx;
    logic signed [ACC_W-1:0]  r_acc, w_acc_nx;
    logic [1:0]               r_mode, w_mode_nx;
    logic                     r_out_valid, w_out_valid_nx;
    logic [N-1:0]             r_out_data, w_out_data_nx;

    logic signed [2*N-1:0]    w_prod [LANES];
    logic signed [ACC_W-1:0]  w_beat_sum;
    logic signed [ACC_W-1:0]  w_bias_ext;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_prod[g] = $signed(bus.w[g*N +: N]) * $signed(bus.x[g*N +: N]);
    end

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_beat_sum = w_beat_sum
                + {{(ACC_W-2*N){w_prod[i][2*N-1]}}, w_prod[i]};
        end
    end

    // Bias is Q.FRAC, products Q.2FRAC: align bias before adding.
    assign w_bias_ext = {{(ACC_W-N){bus.bias[N-1]}}, bus.bias} <<< FRAC;

    function automatic logic [N-1:0] act(
        input logic signed [ACC_W-1:0] a,
        input logic [1:0]              m
    );
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] t;
        s = a >>> FRAC;
        t = s;
        case (m)
            2'd1:    if (s[ACC_W-1]) t = '0;
            2'd2:    if (s[ACC_W-1]) t = s >>> 3;
            default: t = s;
        endcase
        if (t > SAT_HI) return SAT_HI[N-1:0];
        if (t < SAT_LO) return SAT_LO[N-1:0];
        return t[N-1:0];
    endfunction

    always_comb begin
        w_state_nx     = r_state;
        w_beat_cnt_nx  = r_beat_cnt;
        w_acc_nx       = r_acc;
        w_mode_nx      = r_mode;
        w_out_valid_nx = r_out_valid;
        w_out_data_nx  = r_out_data;
        unique case (r_state)
            S_ACC: begin
                if (bus.in_valid) begin
                    if (r_beat_cnt == '0) begin
                        w_acc_nx  = w_bias_ext + w_beat_sum;
                        w_mode_nx = bus.mode;
                    end else begin
                        w_acc_nx = r_acc + w_beat_sum;
                    end
                    if (r_beat_cnt == CNT_W'(BEATS - 1)) begin
                        w_beat_cnt_nx = '0;
                        w_state_nx    = S_ACT;
                    end else begin
                        w_beat_cnt_nx = r_beat_cnt + 1'b1;
                    end
                end
            end
            S_ACT: begin
                w_out_data_nx  = act(r_acc, r_mode);
                w_out_valid_nx = 1'b1;
                w_state_nx     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_out_valid_nx = 1'b0;
                    w_state_nx     = S_ACC;
                end
            end
            default: w_state_nx = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_ACC;
            r_beat_cnt  <= '0;
            r_acc       <= '0;
            r_mode      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_beat_cnt  <= w_beat_cnt_nx;
            r_acc       <= w_acc_nx;
            r_mode      <= w_mode_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_data  <= w_out_data_nx;
        end
    end

    // Ready is withheld during reset so no beat is lost to a discarded vector.
    assign bus.in_ready  = rst_n && (r_state == S_ACC);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
